// File: rtl/gpio_lb_arbiter.sv
// gpio_lb_arbiter: two-master round-robin front end for the GPIO local-bus
// slave port. One transaction in flight, fixed write hold, read on rdy/timeout.
// Ports: clk_lb/reset_n; m0_*/m1_* (wr, rd, addr, wr_d in; ack, rd_d, timeout
// out); lb_wr/lb_rd/lb_addr/lb_wr_d to the slave, lb_rd_d/lb_rd_rdy from it.
module gpio_lb_arbiter #(
   parameter int          WR_HOLD    = 2,
   parameter int          TIMEOUT    = 16,
   parameter int          TMO_BITS   = 5,
   parameter logic [31:0] RD_DEFAULT = 32'hDEADBEEF
) (
   input  logic        clk_lb,
   input  logic        reset_n,
   input  logic        m0_wr,
   input  logic        m0_rd,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wr_d,
   output logic        m0_ack,
   output logic [31:0] m0_rd_d,
   output logic        m0_timeout,
   input  logic        m1_wr,
   input  logic        m1_rd,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wr_d,
   output logic        m1_ack,
   output logic [31:0] m1_rd_d,
   output logic        m1_timeout,
   output logic        lb_wr,
   output logic        lb_rd,
   output logic [31:0] lb_addr,
   output logic [31:0] lb_wr_d,
   input  logic [31:0] lb_rd_d,
   input  logic        lb_rd_rdy
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WR_WAIT = 3'd2;
   localparam logic [2:0] RD_WAIT = 3'd3;
   localparam logic [2:0] ACK     = 3'd4;

   localparam logic [TMO_BITS-1:0] HOLD_LAST = TMO_BITS'(WR_HOLD - 1);
   localparam logic [TMO_BITS-1:0] TMO_LAST  = TMO_BITS'(TIMEOUT - 1);

   logic [2:0]          state;
   logic [TMO_BITS-1:0] cnt;
   logic                gnt;
   logic                last_grant;
   logic                is_wr;

   logic        m0_req;
   logic        m1_req;
   logic        pick;
   logic        pick_wr;
   logic        fin;
   logic        fin_tmo;
   logic [31:0] fin_d;

   assign m0_req = m0_wr | m0_rd;
   assign m1_req = m1_wr | m1_rd;

   // A tie goes to whichever master was not served last.
   assign pick    = (m0_req & m1_req) ? ~last_grant : m1_req;
   // Write takes precedence when a master raises both wr and rd.
   assign pick_wr = pick ? m1_wr : m0_wr;

   // Completion of the wait states; rdy beats a same-cycle timeout.
   always_comb begin
      fin     = 1'b0;
      fin_tmo = 1'b0;
      fin_d   = '0;
      case (state)
         WR_WAIT: fin = (cnt == HOLD_LAST);
         RD_WAIT: begin
            if (lb_rd_rdy) begin
               fin   = 1'b1;
               fin_d = lb_rd_d;
            end else if (cnt == TMO_LAST) begin
               fin     = 1'b1;
               fin_d   = RD_DEFAULT;
               fin_tmo = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_lb or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         is_wr      <= 1'b0;
         lb_wr      <= 1'b0;
         lb_rd      <= 1'b0;
         lb_addr    <= '0;
         lb_wr_d    <= '0;
         m0_ack     <= 1'b0;
         m0_rd_d    <= '0;
         m0_timeout <= 1'b0;
         m1_ack     <= 1'b0;
         m1_rd_d    <= '0;
         m1_timeout <= 1'b0;
      end else begin
         // Strobes and completion outputs are single-cycle pulses.
         lb_wr      <= 1'b0;
         lb_rd      <= 1'b0;
         m0_ack     <= 1'b0;
         m0_rd_d    <= '0;
         m0_timeout <= 1'b0;
         m1_ack     <= 1'b0;
         m1_rd_d    <= '0;
         m1_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_req | m1_req) begin
                  gnt     <= pick;
                  is_wr   <= pick_wr;
                  lb_wr   <= pick_wr;
                  lb_rd   <= ~pick_wr;
                  lb_addr <= pick ? m1_addr : m0_addr;
                  lb_wr_d <= pick ? m1_wr_d : m0_wr_d;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= is_wr ? WR_WAIT : RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
               cnt <= cnt + TMO_BITS'(1);
               if (fin) begin
                  state <= ACK;
                  if (gnt) begin
                     m1_ack     <= 1'b1;
                     m1_rd_d    <= fin_d;
                     m1_timeout <= fin_tmo;
                  end else begin
                     m0_ack     <= 1'b1;
                     m0_rd_d    <= fin_d;
                     m0_timeout <= fin_tmo;
                  end
               end
            end
            ACK: begin
               last_grant <= gnt;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_lb_arbiter.sv
// tb_gpio_lb_arbiter: directed and random transactions against a
// transaction-level model of grant order, latency and returned data.
module tb_gpio_lb_arbiter;

   localparam int          WR_HOLD    = 2;
   localparam int          TIMEOUT    = 16;
   localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;

   logic        clk_lb = 1'b0;
   logic        reset_n = 1'b0;
   logic        rq_wr [2];
   logic        rq_rd [2];
   logic [31:0] rq_addr [2];
   logic [31:0] rq_wd [2];
   logic        m0_ack, m1_ack, m0_timeout, m1_timeout;
   logic [31:0] m0_rd_d, m1_rd_d;
   logic        lb_wr, lb_rd, lb_rd_rdy;
   logic [31:0] lb_addr, lb_wr_d, lb_rd_d;

   int          n_vec = 0;
   int          n_bad = 0;
   int          last = 1;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_wd = '0;

   always #5 clk_lb = ~clk_lb;

   gpio_lb_arbiter dut (
      .clk_lb     (clk_lb),
      .reset_n    (reset_n),
      .m0_wr      (rq_wr[0]),
      .m0_rd      (rq_rd[0]),
      .m0_addr    (rq_addr[0]),
      .m0_wr_d    (rq_wd[0]),
      .m0_ack     (m0_ack),
      .m0_rd_d    (m0_rd_d),
      .m0_timeout (m0_timeout),
      .m1_wr      (rq_wr[1]),
      .m1_rd      (rq_rd[1]),
      .m1_addr    (rq_addr[1]),
      .m1_wr_d    (rq_wd[1]),
      .m1_ack     (m1_ack),
      .m1_rd_d    (m1_rd_d),
      .m1_timeout (m1_timeout),
      .lb_wr      (lb_wr),
      .lb_rd      (lb_rd),
      .lb_addr    (lb_addr),
      .lb_wr_d    (lb_wr_d),
      .lb_rd_d    (lb_rd_d),
      .lb_rd_rdy  (lb_rd_rdy)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic chk_cycle(input string tag, input logic [5:0] ctl_e,
                            input logic [31:0] d0_e, input logic [31:0] d1_e);
      chk({tag, ".ctl"},
          {lb_wr, lb_rd, m0_ack, m1_ack, m0_timeout, m1_timeout}, ctl_e);
      chk({tag, ".addr"}, lb_addr, exp_addr);
      chk({tag, ".wd"}, lb_wr_d, exp_wd);
      chk({tag, ".rd0"}, m0_rd_d, d0_e);
      chk({tag, ".rd1"}, m1_rd_d, d1_e);
   endtask

   function automatic bit req(input int i);
      return rq_wr[i] | rq_rd[i];
   endfunction

   // kind: 0 write, 1 read, 2 write+read (write wins)
   task automatic new_req(input int i, input int kind);
      rq_wr[i]   = (kind != 1);
      rq_rd[i]   = (kind != 0);
      rq_addr[i] = $urandom;
      rq_wd[i]   = $urandom;
   endtask

   task automatic idle_cycle();
      lb_rd_rdy = ($urandom_range(0, 3) == 0);
      lb_rd_d   = $urandom;
      @(negedge clk_lb);
      chk_cycle("idle", 6'b0, '0, '0);
      @(posedge clk_lb);
      #1;
      lb_rd_rdy = 1'b0;
   endtask

   // Entered in an idle cycle with requests pending. rdy_cyc: cycle of the
   // slave rdy pulse counted from the grant decision (0 = never).
   task automatic serve(input int rdy_cyc, input bit keep, input bit late,
                        input int abort_c, input logic [31:0] rdata);
      int          w;
      int          ack_c;
      bit          wr;
      bit          tmo;
      bit          a;
      logic [31:0] data;
      if (req(0) && req(1)) w = (last == 1) ? 0 : 1;
      else w = req(1) ? 1 : 0;
      wr = rq_wr[w];
      if (wr) begin
         ack_c = WR_HOLD + 2;
         data  = '0;
         tmo   = 1'b0;
      end else if (rdy_cyc != 0) begin
         ack_c = rdy_cyc + 1;
         data  = rdata;
         tmo   = 1'b0;
      end else begin
         ack_c = TIMEOUT + 2;
         data  = RD_DEFAULT;
         tmo   = 1'b1;
      end
      @(negedge clk_lb);
      chk_cycle("pend", 6'b0, '0, '0);
      @(posedge clk_lb);
      #1;
      exp_addr = rq_addr[w];
      exp_wd   = rq_wd[w];
      for (int c = 1; c <= ack_c; c++) begin
         if (!wr && c >= 2 && c < ack_c) lb_rd_rdy = (c == rdy_cyc);
         else if (!wr && c == ack_c && rdy_cyc == 0) lb_rd_rdy = 1'b1;
         else lb_rd_rdy = ($urandom_range(0, 3) == 0);
         lb_rd_d = (c == rdy_cyc) ? rdata : 32'($urandom);
         if (late && !req(1 - w) && $urandom_range(0, 5) == 0)
            new_req(1 - w, $urandom_range(0, 2));
         if (c == abort_c) begin
            #1 reset_n = 1'b0;
            #1;
            exp_addr = '0;
            exp_wd   = '0;
            chk_cycle("rst", 6'b0, '0, '0);
            for (int i = 0; i < 2; i++) begin
               rq_wr[i] = 1'b0;
               rq_rd[i] = 1'b0;
            end
            lb_rd_rdy = 1'b0;
            @(posedge clk_lb);
            #2 reset_n = 1'b1;
            last = 1;
            return;
         end
         @(negedge clk_lb);
         a = (c == ack_c);
         chk_cycle("txn",
                   {c == 1 && wr, c == 1 && !wr, a && w == 0, a && w == 1,
                    a && w == 0 && tmo, a && w == 1 && tmo},
                   (a && w == 0) ? data : 32'h0,
                   (a && w == 1) ? data : 32'h0);
         @(posedge clk_lb);
         #1;
      end
      lb_rd_rdy = 1'b0;
      if (!keep) begin
         rq_wr[w] = 1'b0;
         rq_rd[w] = 1'b0;
      end
      last = w;
   endtask

   initial begin
      int m;
      int r;
      for (int i = 0; i < 2; i++) begin
         rq_wr[i]   = 1'b0;
         rq_rd[i]   = 1'b0;
         rq_addr[i] = '0;
         rq_wd[i]   = '0;
      end
      lb_rd_rdy = 1'b0;
      lb_rd_d   = '0;
      repeat (2) @(posedge clk_lb);
      #1;
      chk_cycle("reset", 6'b0, '0, '0);
      reset_n = 1'b1;
      repeat (2) idle_cycle();

      // m0 write, ack in cycle 4
      rq_wr[0] = 1'b1; rq_addr[0] = 32'h20; rq_wd[0] = 32'h77777777;
      serve(0, 1'b0, 1'b0, 0, '0);
      // m0 read with no rdy: timeout word, late rdy ignored
      rq_rd[0] = 1'b1; rq_addr[0] = 32'h40;
      serve(0, 1'b0, 1'b0, 0, '0);
      idle_cycle();
      // m1 read, rdy two cycles after the strobe
      rq_rd[1] = 1'b1; rq_addr[1] = 32'h30;
      serve(3, 1'b0, 1'b0, 0, 32'h0000AB00);
      // both masters hold requests: alternating grants starting at m0
      new_req(0, 0);
      new_req(1, 1);
      for (int k = 0; k < 4; k++)
         serve($urandom_range(2, 17), 1'b1, 1'b0, 0, $urandom);
      for (int i = 0; i < 2; i++) begin
         rq_wr[i] = 1'b0;
         rq_rd[i] = 1'b0;
      end
      idle_cycle();
      // rdy on the timeout cycle wins
      new_req(1, 1);
      serve(17, 1'b0, 1'b0, 0, 32'h13572468);
      // reset in RD_WAIT, then a normal transaction
      new_req(0, 1);
      serve(0, 1'b0, 1'b0, 5, '0);
      repeat (3) idle_cycle();
      new_req(1, 0);
      serve(0, 1'b0, 1'b0, 0, '0);
      // reset mid-write with both masters requesting
      new_req(0, 0);
      new_req(1, 2);
      serve(0, 1'b0, 1'b0, 3, '0);
      repeat (3) idle_cycle();
      new_req(0, 0);
      new_req(1, 1);
      serve(4, 1'b0, 1'b0, 0, $urandom);

      for (int t = 0; t < 150; t++) begin
         if (!req(0) && !req(1)) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            m = $urandom_range(1, 3);
            if (m[0]) new_req(0, $urandom_range(0, 2));
            if (m[1]) new_req(1, $urandom_range(0, 2));
         end
         r = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 17);
         serve(r, 1'b0, 1'b1, 0, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
